// File: rtl/peak_tracker.sv
// rtl/peak_tracker.sv - windowed maximum tracker using an external 4-bit magnitude comparator.
// Optional tie counting is enabled by defining PEAK_TIE_COUNT_EN; otherwise out_ties is tied to 0.
module peak_tracker #(
    parameter int WIN_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] cmp_a,
    output logic [3:0] cmp_b,
    input  logic       cmp_greater,
    input  logic       cmp_equal,
    output logic [3:0] out_max,
    output logic [3:0] out_idx,
    output logic [3:0] out_ties,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [1:0] {
        ACCEPT,
        COMPARE,
        REPORT
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [4:0] cnt;
    logic [3:0] hold;
    logic [3:0] hold_idx;
    logic [3:0] max_r;
    logic [3:0] idx_r;
    logic       take;
    logic       first;
    logic       last;

    assign take      = in_valid && in_ready;
    assign first     = (cnt == 5'd0);
    assign last      = (cnt == 5'(WIN_LEN));
    assign in_ready  = (state == ACCEPT);
    assign out_valid = (state == REPORT);
    assign cmp_a     = hold;
    assign cmp_b     = max_r;
    assign out_max   = max_r;
    assign out_idx   = idx_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCEPT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ACCEPT: begin
                if (take && !first) begin
                    state_nx = COMPARE;
                end
            end
            COMPARE: begin
                state_nx = last ? REPORT : ACCEPT;
            end
            REPORT: begin
                if (out_ready) begin
                    state_nx = ACCEPT;
                end
            end
            default: state_nx = ACCEPT;
        endcase
    end

    // cnt counts samples accepted so far, so hold_idx is the 0-based position of the held sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 5'd0;
            hold     <= 4'd0;
            hold_idx <= 4'd0;
            max_r    <= 4'd0;
            idx_r    <= 4'd0;
        end else begin
            if (take) begin
                hold     <= in_data;
                hold_idx <= cnt[3:0];
                cnt      <= cnt + 5'd1;
                if (first) begin
                    max_r <= in_data;
                    idx_r <= 4'd0;
                end
            end
            if (state == COMPARE && cmp_greater) begin
                max_r <= hold;
                idx_r <= hold_idx;
            end
            if (state == REPORT && out_ready) begin
                cnt <= 5'd0;
            end
        end
    end

`ifdef PEAK_TIE_COUNT_EN
    logic [3:0] ties_r;

    // greater wins over equal, and a new maximum restarts the tie count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ties_r <= 4'd0;
        end else if (take && first) begin
            ties_r <= 4'd0;
        end else if (state == COMPARE) begin
            if (cmp_greater) begin
                ties_r <= 4'd0;
            end else if (cmp_equal && ties_r != 4'd15) begin
                ties_r <= ties_r + 4'd1;
            end
        end
    end

    assign out_ties = ties_r;
`else
    logic unused_cmp_equal;

    assign unused_cmp_equal = cmp_equal;
    assign out_ties         = 4'd0;
`endif

endmodule

// File: tb/tb_peak_tracker.sv
// tb/tb_peak_tracker.sv - self-checking bench for peak_tracker with a behavioural window model.
module tb_peak_tracker;

    localparam int WIN = 8;
`ifdef PEAK_TIE_COUNT_EN
    localparam bit TIES_EN = 1'b1;
`else
    localparam bit TIES_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       both_mode = 1'b0;
    logic       in_ready;
    logic [3:0] cmp_a;
    logic [3:0] cmp_b;
    logic       cmp_greater;
    logic       cmp_equal;
    logic [3:0] out_max;
    logic [3:0] out_idx;
    logic [3:0] out_ties;
    logic       out_valid;

    int checks = 0;
    int failures = 0;

    peak_tracker #(.WIN_LEN(WIN)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .cmp_a(cmp_a),
        .cmp_b(cmp_b),
        .cmp_greater(cmp_greater),
        .cmp_equal(cmp_equal),
        .out_max(out_max),
        .out_idx(out_idx),
        .out_ties(out_ties),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // external comparator; both_mode makes it assert greater and equal together on a tie
    assign cmp_greater = (cmp_a > cmp_b) || (both_mode && (cmp_a == cmp_b));
    assign cmp_equal   = (cmp_a == cmp_b);

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int mx;
        int ix;
        int ti;
    } res_t;

    res_t expq[$];
    int   wcnt = 0;
    int   rmax = 0;
    int   ridx = 0;
    int   rties = 0;
    bit   cmp_due = 0;
    bit   cmp_last = 0;
    bit   vcheck = 0;
    bit   rdy_check = 0;
    int   e_a = 0;
    int   e_b = 0;
    bit   e_gt = 0;

    // model: running maximum over accepted samples, first occurrence wins, ties counted on arrival
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expq.delete();
            wcnt = 0;
            rmax = 0;
            ridx = 0;
            rties = 0;
            cmp_due = 0;
            cmp_last = 0;
            vcheck = 0;
            rdy_check = 0;
        end else begin
            int s;
            vcheck = cmp_due && cmp_last;
            rdy_check = out_valid && out_ready;
            if (out_valid && out_ready && expq.size() > 0) begin
                void'(expq.pop_front());
            end
            cmp_due = 0;
            cmp_last = 0;
            if (in_valid && in_ready) begin
                s = int'(in_data);
                if (wcnt == 0) begin
                    rmax = s;
                    ridx = 0;
                    rties = 0;
                end else begin
                    cmp_due = 1;
                    e_a = s;
                    e_b = rmax;
                    e_gt = (s > rmax);
                    if (s > rmax || (both_mode && s == rmax)) begin
                        rmax = s;
                        ridx = wcnt;
                        rties = 0;
                    end else if (s == rmax && TIES_EN && rties < 15) begin
                        rties++;
                    end
                end
                wcnt++;
                if (wcnt == WIN) begin
                    expq.push_back('{rmax, ridx, rties});
                    wcnt = 0;
                    cmp_last = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmp_due) begin
                check("busy_in_compare", in_ready, 0);
                check("cmp_a_held", cmp_a, e_a[7:0]);
                check("cmp_b_max", cmp_b, e_b[7:0]);
                if (!both_mode) check("cmp_greater", cmp_greater, e_gt);
            end
            if (vcheck) check("valid_after_last", out_valid, 1);
            if (rdy_check) begin
                check("ready_after_release", in_ready, 1);
                check("valid_dropped", out_valid, 0);
            end
            if (out_valid) begin
                check("report_pending", expq.size(), 1);
                check("ready_low_in_report", in_ready, 0);
                if (expq.size() > 0) begin
                    check("model_max", out_max, expq[0].mx[7:0]);
                    check("model_idx", out_idx, expq[0].ix[7:0]);
                    check("model_ties", out_ties, expq[0].ti[7:0]);
                end
            end
        end
    end

    task automatic send(input logic [3:0] v);
        int n = 0;
        bit got = 0;
        in_data = v;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!got && n < 50);
        check("send_accepted", got, 1);
        in_valid = 1'b0;
    endtask

    task automatic run_window(input logic [31:0] seq, input int gap, input int hold,
                              input int emax, input int eidx, input int eties, input string tag);
        int n = 0;
        out_ready = (hold == 0);
        for (int i = 0; i < WIN; i++) begin
            send(seq[31-4*i -: 4]);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 30);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_max"}, out_max, emax[7:0]);
        check({tag, "_idx"}, out_idx, eidx[7:0]);
        check({tag, "_ties"}, out_ties, eties[7:0]);
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                check({tag, "_hold_max"}, out_max, emax[7:0]);
                check({tag, "_hold_valid"}, out_valid, 1);
                check({tag, "_hold_ready"}, in_ready, 0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_max", out_max, 0);
        check("rst_idx", out_idx, 0);
        check("rst_ties", out_ties, 0);
        check("rst_valid", out_valid, 0);
        check("rst_cmp_a", cmp_a, 0);
        check("rst_cmp_b", cmp_b, 0);
        check("rst_ready", in_ready, 1);
        rst_n = 1'b1;

        run_window(32'h37299104, 0, 0, 9, 3, TIES_EN ? 1 : 0, "basic");
        run_window(32'h55555555, 0, 0, 5, 0, TIES_EN ? 7 : 0, "all5");
        run_window(32'hFEDCBA98, 0, 0, 15, 0, 0, "desc");
        run_window(32'h37299104, 0, 10, 9, 3, TIES_EN ? 1 : 0, "stall");
        run_window(32'h37299104, 1, 0, 9, 3, TIES_EN ? 1 : 0, "toggle");
        both_mode = 1'b1;
        run_window(32'h55555555, 0, 0, 5, 7, 0, "both");
        both_mode = 1'b0;

        for (int i = 0; i < 4; i++) send(4'(i + 10));
        rst_n = 1'b0;
        #1;
        check("midrst_max", out_max, 0);
        check("midrst_idx", out_idx, 0);
        check("midrst_ties", out_ties, 0);
        check("midrst_cmp_a", cmp_a, 0);
        check("midrst_cmp_b", cmp_b, 0);
        check("midrst_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_ready", in_ready, 1);
        run_window(32'h12345678, 0, 0, 8, 7, 0, "afterrst");

        repeat (800) begin
            @(posedge clk);
            #1;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(6, 8));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("drain_empty", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
